// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, CLK_PER_BIT clocks per serial bit.
// The received byte is held in a one-entry valid/ready output buffer.
//
// Ports:
//   i_clk        - sole clock, rising edge
//   i_rst        - synchronous active-high reset
//   i_rx         - asynchronous serial line, idles high
//   o_data       - last correctly framed byte
//   o_data_valid - o_data holds a byte not yet consumed
//   i_data_rdy   - consumer ready; transfer when o_data_valid && i_data_rdy
//   o_frame_err  - one-cycle pulse: stop bit sampled low
//   o_overrun    - one-cycle pulse: good byte dropped, buffer full
module uart_rx #(
  parameter int unsigned CLK_PER_BIT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  input  logic       i_data_rdy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT);

  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state_q;
  logic          rx_m_q;
  logic          rx_s_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          overrun_q;

  logic xfer;
  assign xfer = valid_q && i_data_rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      rx_m_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_m_q      <= i_rx;
      rx_s_q      <= rx_m_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consumer transfer; a delivery in the same cycle below overrides it.
      if (xfer) valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end

        // Wait half a bit, then confirm the start bit is still low.
        START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= DATA;
              idx_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        // Returning straight to IDLE lets a start bit that begins right
        // after the stop sample be caught without loss.
        STOP: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
              if (!valid_q || xfer) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              state_q     <= WAIT_IDLE;
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        WAIT_IDLE: begin
          if (rx_s_q) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_frame_err  = frame_err_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with CLK_PER_BIT = 4.
module tb_uart_rx;

  localparam int unsigned CPB = 4;

  logic       i_clk;
  logic       i_rst;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       i_data_rdy;
  logic       o_frame_err;
  logic       o_overrun;

  int unsigned checks;
  int unsigned errors;

  // Event tallies gathered on the falling edge.
  int unsigned xfer_cnt;
  int unsigned valid_cyc;
  int unsigned fe_cnt;
  int unsigned ov_cnt;
  logic [7:0]  rxq[$];

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_rdy   (i_data_rdy),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    xfer_cnt  = 0;
    valid_cyc = 0;
    fe_cnt    = 0;
    ov_cnt    = 0;
  end

  always @(negedge i_clk) begin
    if (o_data_valid) valid_cyc = valid_cyc + 1;
    if (o_data_valid && i_data_rdy) begin
      xfer_cnt = xfer_cnt + 1;
      rxq.push_back(o_data);
    end
    if (o_frame_err) fe_cnt = fe_cnt + 1;
    if (o_overrun)   ov_cnt = ov_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int unsigned n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int unsigned n);
    i_rx = v;
    cycle(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop, CPB);
    i_rx = 1'b1;
  endtask

  int unsigned x0, v0, f0, o0, q0;

  task automatic snap();
    x0 = xfer_cnt;
    v0 = valid_cyc;
    f0 = fe_cnt;
    o0 = ov_cnt;
    q0 = rxq.size();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    i_rst      = 1'b1;
    i_rx       = 1'b1;
    i_data_rdy = 1'b1;
    cycle(3);
    i_rst = 1'b0;
    check("rst_data",  {24'd0, o_data}, 32'h00);
    check("rst_valid", {31'd0, o_data_valid}, 32'd0);
    check("rst_fe",    {31'd0, o_frame_err}, 32'd0);
    check("rst_ov",    {31'd0, o_overrun}, 32'd0);
    drive_bit(1'b1, 4);

    // Single frame, consumer always ready.
    snap();
    send_byte(8'hA5, 1'b1);
    drive_bit(1'b1, 8);
    check("a5_xfer",   xfer_cnt - x0, 32'd1);
    check("a5_data",   {24'd0, o_data}, 32'hA5);
    check("a5_vcyc",   valid_cyc - v0, 32'd1);
    check("a5_fe",     fe_cnt - f0, 32'd0);
    check("a5_ov",     ov_cnt - o0, 32'd0);

    // One-cycle low glitch on the idle line.
    snap();
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 10);
    check("gl_xfer",   xfer_cnt - x0, 32'd0);
    check("gl_vcyc",   valid_cyc - v0, 32'd0);
    check("gl_fe",     fe_cnt - f0, 32'd0);
    check("gl_ov",     ov_cnt - o0, 32'd0);

    // Framing error, then a good frame.
    snap();
    send_byte(8'h3C, 1'b0);
    drive_bit(1'b1, 6);
    check("fe_pulse",  fe_cnt - f0, 32'd1);
    check("fe_vcyc",   valid_cyc - v0, 32'd0);
    check("fe_valid",  {31'd0, o_data_valid}, 32'd0);
    snap();
    send_byte(8'h81, 1'b1);
    drive_bit(1'b1, 8);
    check("f81_xfer",  xfer_cnt - x0, 32'd1);
    check("f81_data",  {24'd0, rxq[q0]}, 32'h81);
    check("f81_fe",    fe_cnt - f0, 32'd0);

    // Consumer stalled: second byte overruns.
    i_data_rdy = 1'b0;
    snap();
    send_byte(8'h11, 1'b1);
    drive_bit(1'b1, 2);
    send_byte(8'h22, 1'b1);
    drive_bit(1'b1, 8);
    check("ov_data",   {24'd0, o_data}, 32'h11);
    check("ov_valid",  {31'd0, o_data_valid}, 32'd1);
    check("ov_pulse",  ov_cnt - o0, 32'd1);
    check("ov_noxfer", xfer_cnt - x0, 32'd0);
    i_data_rdy = 1'b1;
    cycle(1);
    check("ov_clr",    {31'd0, o_data_valid}, 32'd0);
    check("ov_xfer",   xfer_cnt - x0, 32'd1);
    check("ov_xdata",  {24'd0, rxq[q0]}, 32'h11);
    check("ov_hold",   {24'd0, o_data}, 32'h11);
    drive_bit(1'b1, 4);

    // Back-to-back frames.
    snap();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    drive_bit(1'b1, 8);
    check("b2b_xfer",  xfer_cnt - x0, 32'd2);
    check("b2b_d0",    {24'd0, rxq[q0]}, 32'h00);
    check("b2b_d1",    {24'd0, rxq[q0 + 1]}, 32'hFF);

    // Reset during data bit 3 of 0x5A.
    snap();
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, 2);
    i_rst = 1'b1;
    i_rx  = 1'b1;
    cycle(1);
    i_rst = 1'b0;
    check("mr_data",   {24'd0, o_data}, 32'h00);
    check("mr_valid",  {31'd0, o_data_valid}, 32'd0);
    check("mr_fe",     {31'd0, o_frame_err}, 32'd0);
    check("mr_ov",     {31'd0, o_overrun}, 32'd0);
    drive_bit(1'b1, 40);
    check("mr_nodel",  xfer_cnt - x0, 32'd0);
    check("mr_noflag", (fe_cnt - f0) + (ov_cnt - o0), 32'd0);
    snap();
    send_byte(8'h5A, 1'b1);
    drive_bit(1'b1, 8);
    check("mr_xfer",   xfer_cnt - x0, 32'd1);
    check("mr_5a",     {24'd0, rxq[q0]}, 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_PER_BIT, default 4: clock cycles per serial bit; legal values are integers >= 4.
REQ-002 i_clk  input  1  Sole clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  Synchronous, active-high reset, sampled on the i_clk rising edge.
REQ-004 i_rx  input  1  Asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-005 o_data  output  8  Last correctly framed received byte.
REQ-006 o_data_valid  output  1  High while o_data holds a byte not yet consumed.
REQ-007 i_data_rdy  input  1  Consumer ready; a transfer occurs on any cycle where o_data_valid && i_data_rdy.
REQ-008 o_frame_err  output  1  One-cycle pulse when a stop bit is sampled low.
REQ-009 o_overrun  output  1  One-cycle pulse when a good byte is dropped because the output buffer is full.

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer; all logic below uses only the synchronized value (rx_s).
REQ-011 States SHALL be: IDLE, START, DATA, STOP, WAIT_IDLE; a single bit counter (clog2(CLK_PER_BIT) bits) and a 3-bit data index.
REQ-012 IDLE: on rx_s == 0, go to START with the bit counter cleared.
REQ-013 START: after CLK_PER_BIT/2 cycles (integer division), sample rx_s; 0 -> DATA with the bit counter cleared; 1 -> IDLE (glitch rejected, no flags).
REQ-014 DATA: sample rx_s every CLK_PER_BIT cycles into bit[index], index 0..7; after bit 7 go to STOP.
REQ-015 STOP: after CLK_PER_BIT cycles, sample rx_s; 1 -> deliver byte (REQ-016), go to IDLE; 0 -> pulse o_frame_err, discard byte, go to WAIT_IDLE.
REQ-016 Delivery: if the buffer is empty or a transfer occurs in the same cycle, load o_data and set o_data_valid on the next edge; otherwise keep the old o_data/o_data_valid, pulse o_overrun, and drop the new byte.
REQ-017 WAIT_IDLE: remain until rx_s == 1, then go to IDLE; this state SHALL NOT detect start bits.
REQ-018 Transfer with no simultaneous delivery SHALL clear o_data_valid on the next edge; o_data SHALL be held unchanged.
REQ-019 o_data and o_data_valid SHALL be registered and SHALL be stable while o_data_valid is high and i_data_rdy is low.
REQ-020 Back-to-back frames: a start bit beginning at the end of the stop-bit sample cycle SHALL be detected with no lost frame.
REQ-021 The bit counter SHALL wrap to 0 on reaching CLK_PER_BIT-1; there SHALL be no other counter wrap.
REQ-022 o_frame_err and o_overrun SHALL never be asserted on consecutive cycles for the same event.

Reset
REQ-023 On i_rst: state=IDLE; counters=0; sync flops=1; o_data=8'h00; o_data_valid=0; o_frame_err=0; o_overrun=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no flags; the frame SHALL NOT be delivered.
REQ-025 i_rst SHALL override every other input on the same edge.

Verification
REQ-026 CLK_PER_BIT=4, frame 0xA5, i_data_rdy=1 -> o_data=8'hA5, o_data_valid high for exactly 1 cycle, no flags.
REQ-027 Low glitch of 1 cycle on idle i_rx -> no o_data_valid, no flags; the state returns to IDLE.
REQ-028 Frame 0x3C with stop bit forced low, then line high -> o_frame_err 1-cycle pulse, o_data_valid stays 0, the next frame 0x81 is received as 8'h81.
REQ-029 i_data_rdy=0, frames 0x11 then 0x22 -> o_data=8'h11 held valid, o_overrun pulse at 0x22 stop sample; with rdy=1 afterward, the transfer yields 8'h11.
REQ-030 Back-to-back frames 0x00, 0xFF with rdy=1 -> two deliveries, 8'h00 then 8'hFF.
REQ-031 Assert i_rst during DATA bit 3 of 0x5A -> all outputs at reset values next cycle; a subsequent frame 0x5A is received correctly.
